// File: rtl/seg7_pkg.sv
// Shared types and default constants for the seven-segment scan blocks.
package seg7_pkg;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_t;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DIV_WIDTH    = 17;
    localparam int DEF_BLANK_CYCLES = 64;

endpackage

// File: rtl/anode_scan_timer_slot_prescaler.sv
// Slot prescaler: counts 0..tc, wraps to 0 after tc, flags the terminal count.
// clr has priority over counting; while run is low and clr is low the count holds.
module slot_prescaler #(
    parameter int DIV_WIDTH = seg7_pkg::DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] tc,
    output logic [DIV_WIDTH-1:0] cnt,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;

    assign cnt  = cnt_q;
    assign tick = (cnt_q == tc);

    // Count register: clear, wrap at terminal count, or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/anode_scan_timer.sv
// Digit-scan timer for a multiplexed seven-segment display. Each slot lasts
// period_q+1 clocks; the first BLANK_CYCLES clocks of a slot keep all anodes
// off to suppress ghosting. period and digit_mask are captured only when a
// scan starts and at slot boundaries, so a slot never changes length or mask
// part-way through. Every output is decoded from registers only.
module anode_scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DIV_WIDTH-1:0]  period,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [IDX_W-1:0]      digit_sel,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic                  slot_tick,
    output logic                  frame_tick
);

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_W  = DIV_WIDTH'(BLANK_CYCLES);

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      digit_sel_q;
    logic [DIV_WIDTH-1:0]  period_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [DIV_WIDTH-1:0]  cnt;
    logic                  tick;
    logic                  running;

    assign running = (state_q == SCAN_RUN);

    // Counter is held at zero whenever the next cycle is not a running cycle.
    slot_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!running || !en),
        .run   (running),
        .tc    (period_q),
        .cnt   (cnt),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: en starts the scan and dropping en abandons it at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN_IDLE: if (en)  state_d = SCAN_RUN;
            SCAN_RUN:  if (!en) state_d = SCAN_IDLE;
            default:   state_d = SCAN_IDLE;
        endcase
    end

    // Digit index and captured period/mask; reload at start and slot ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_q <= '0;
            period_q    <= '0;
            mask_q      <= '0;
        end else if (!running || !en) begin
            digit_sel_q <= '0;
            if (!running && en) begin
                period_q <= period;
                mask_q   <= digit_mask;
            end else begin
                period_q <= '0;
                mask_q   <= '0;
            end
        end else if (tick) begin
            digit_sel_q <= (digit_sel_q == LAST_IDX) ? '0 : digit_sel_q + 1'b1;
            period_q    <= period;
            mask_q      <= digit_mask;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign slot_tick  = running && tick;
    assign frame_tick = running && tick && (digit_sel_q == LAST_IDX);

    // Anode decode: at most the current digit lights, after the dead-time.
    always_comb begin
        anode_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (running && (cnt >= BLANK_W) && (digit_sel_q == IDX_W'(i)) && !mask_q[i]) begin
                anode_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_anode_scan_timer.sv
// Directed bench for anode_scan_timer with 4 digits, 8-bit prescaler and a
// 2-cycle dead-time. Inputs change and outputs are sampled on the falling edge.
module tb_anode_scan_timer;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] period = 8'd9;
    logic [ND-1:0] digit_mask = '0;
    logic [1:0]    digit_sel;
    logic [ND-1:0] anode_n;
    logic          slot_tick;
    logic          frame_tick;

    int checks = 0;
    int failures = 0;

    anode_scan_timer #(
        .NUM_DIGITS   (ND),
        .DIV_WIDTH    (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .period     (period),
        .digit_mask (digit_mask),
        .digit_sel  (digit_sel),
        .anode_n    (anode_n),
        .slot_tick  (slot_tick),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Expected anode pattern for digit s at count k, honouring the dead-time.
    function automatic logic [ND-1:0] exp_anode(input int s, input int k, input logic masked);
        logic [ND-1:0] v;
        v = '1;
        if (k >= BL && !masked) v[s] = 1'b0;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (anode_n !== 4'hF)   begin failures++; $display("FAIL reset_anode got=%h exp=F", anode_n); end
        if (digit_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", digit_sel); end
        if (slot_tick !== 1'b0) begin failures++; $display("FAIL reset_slot got=%b exp=0", slot_tick); end
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_tick); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (anode_n !== 4'hF) begin failures++; $display("FAIL idle_anode got=%h exp=F", anode_n); end
    endtask

    // Enable and check the first full 10-cycle slot on digit 0.
    task automatic test_enable();
        period = 8'd9;
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks += 4;
            if (digit_sel !== 2'd0) begin failures++; $display("FAIL en_sel k=%0d got=%0d exp=0", k, digit_sel); end
            if (anode_n !== exp_anode(0, k, 1'b0)) begin failures++; $display("FAIL en_anode k=%0d got=%b exp=%b", k, anode_n, exp_anode(0, k, 1'b0)); end
            if (slot_tick !== (k == 9)) begin failures++; $display("FAIL en_slot k=%0d got=%b", k, slot_tick); end
            if (frame_tick !== 1'b0) begin failures++; $display("FAIL en_frame k=%0d got=%b exp=0", k, frame_tick); end
        end
    endtask

    // Slots 1..3 then the wrap back to digit 0; one frame pulse in total.
    task automatic test_frame_wrap();
        int frames = 0;
        for (int s = 1; s < 4; s++) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (frame_tick === 1'b1) frames++;
                checks += 4;
                if (digit_sel !== 2'(s)) begin failures++; $display("FAIL fw_sel s=%0d k=%0d got=%0d", s, k, digit_sel); end
                if (anode_n !== exp_anode(s, k, 1'b0)) begin failures++; $display("FAIL fw_anode s=%0d k=%0d got=%b exp=%b", s, k, anode_n, exp_anode(s, k, 1'b0)); end
                if (slot_tick !== (k == 9)) begin failures++; $display("FAIL fw_slot s=%0d k=%0d got=%b", s, k, slot_tick); end
                if (frame_tick !== (s == 3 && k == 9)) begin failures++; $display("FAIL fw_frame s=%0d k=%0d got=%b", s, k, frame_tick); end
            end
        end
        @(negedge clk);
        checks += 3;
        if (frames != 1) begin failures++; $display("FAIL fw_frame_count got=%0d exp=1", frames); end
        if (digit_sel !== 2'd0) begin failures++; $display("FAIL fw_wrap_sel got=%0d exp=0", digit_sel); end
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL fw_wrap_frame got=%b exp=0", frame_tick); end
    endtask

    // Mask digit 2 from cnt=0 of slot 0: captured at the slot-0 boundary.
    task automatic test_mask();
        digit_mask = 4'b0100;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) digit_mask = 4'b0000;
            for (int k = (s == 0) ? 1 : 0; k < 10; k++) begin
                @(negedge clk);
                checks += 3;
                if (digit_sel !== 2'(s)) begin failures++; $display("FAIL mask_sel s=%0d k=%0d got=%0d", s, k, digit_sel); end
                if (anode_n !== exp_anode(s, k, s == 2)) begin failures++; $display("FAIL mask_anode s=%0d k=%0d got=%b exp=%b", s, k, anode_n, exp_anode(s, k, s == 2)); end
                if (slot_tick !== (k == 9)) begin failures++; $display("FAIL mask_slot s=%0d k=%0d got=%b", s, k, slot_tick); end
            end
        end
    endtask

    // period 9->3 at cnt 5 of slot 0, then period 0, then back to 9.
    task automatic test_period_change();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < ((s == 0) ? 10 : 4); k++) begin
                @(negedge clk);
                checks += 4;
                if (digit_sel !== 2'(s)) begin failures++; $display("FAIL pc_sel s=%0d k=%0d got=%0d", s, k, digit_sel); end
                if (anode_n !== exp_anode(s, k, 1'b0)) begin failures++; $display("FAIL pc_anode s=%0d k=%0d got=%b exp=%b", s, k, anode_n, exp_anode(s, k, 1'b0)); end
                if (slot_tick !== (k == ((s == 0) ? 9 : 3))) begin failures++; $display("FAIL pc_slot s=%0d k=%0d got=%b", s, k, slot_tick); end
                if (frame_tick !== (s == 3 && k == 3)) begin failures++; $display("FAIL pc_frame s=%0d k=%0d got=%b", s, k, frame_tick); end
                if (s == 0 && k == 5) period = 8'd3;
                if (s == 3 && k == 0) period = 8'd0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks += 4;
            if (digit_sel !== 2'(i % 4)) begin failures++; $display("FAIL p0_sel i=%0d got=%0d exp=%0d", i, digit_sel, i % 4); end
            if (anode_n !== 4'hF) begin failures++; $display("FAIL p0_anode i=%0d got=%b exp=1111", i, anode_n); end
            if (slot_tick !== 1'b1) begin failures++; $display("FAIL p0_slot i=%0d got=%b exp=1", i, slot_tick); end
            if (frame_tick !== (i % 4 == 3)) begin failures++; $display("FAIL p0_frame i=%0d got=%b", i, frame_tick); end
        end
        period = 8'd9;
    endtask

    // Drop en at cnt 4 of slot 2, idle, then re-enable from digit 0.
    task automatic test_disable();
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < ((s == 2) ? 5 : 10); k++) begin
                @(negedge clk);
                checks += 3;
                if (digit_sel !== 2'(s)) begin failures++; $display("FAIL dis_sel s=%0d k=%0d got=%0d", s, k, digit_sel); end
                if (anode_n !== exp_anode(s, k, 1'b0)) begin failures++; $display("FAIL dis_anode s=%0d k=%0d got=%b exp=%b", s, k, anode_n, exp_anode(s, k, 1'b0)); end
                if (slot_tick !== (k == 9)) begin failures++; $display("FAIL dis_slot s=%0d k=%0d got=%b", s, k, slot_tick); end
            end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (anode_n !== 4'hF)   begin failures++; $display("FAIL off_anode i=%0d got=%b exp=1111", i, anode_n); end
            if (digit_sel !== 2'd0) begin failures++; $display("FAIL off_sel i=%0d got=%0d exp=0", i, digit_sel); end
            if (slot_tick !== 1'b0) begin failures++; $display("FAIL off_slot i=%0d got=%b exp=0", i, slot_tick); end
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks += 3;
            if (digit_sel !== 2'd0) begin failures++; $display("FAIL re_sel k=%0d got=%0d exp=0", k, digit_sel); end
            if (anode_n !== exp_anode(0, k, 1'b0)) begin failures++; $display("FAIL re_anode k=%0d got=%b exp=%b", k, anode_n, exp_anode(0, k, 1'b0)); end
            if (slot_tick !== (k == 9)) begin failures++; $display("FAIL re_slot k=%0d got=%b", k, slot_tick); end
        end
    endtask

    // Assert rst_n between edges while digit 2 is lit, then restart cleanly.
    task automatic test_async_reset();
        for (int s = 1; s < 3; s++) begin
            for (int k = 0; k < ((s == 2) ? 4 : 10); k++) begin
                @(negedge clk);
                checks += 2;
                if (digit_sel !== 2'(s)) begin failures++; $display("FAIL ar_sel s=%0d k=%0d got=%0d", s, k, digit_sel); end
                if (anode_n !== exp_anode(s, k, 1'b0)) begin failures++; $display("FAIL ar_anode s=%0d k=%0d got=%b exp=%b", s, k, anode_n, exp_anode(s, k, 1'b0)); end
            end
        end
        checks++;
        if (anode_n !== 4'b1011) begin failures++; $display("FAIL ar_pre_anode got=%b exp=1011", anode_n); end
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks += 3;
        if (anode_n !== 4'hF)   begin failures++; $display("FAIL ar_anode_async got=%b exp=1111", anode_n); end
        if (digit_sel !== 2'd0) begin failures++; $display("FAIL ar_sel_async got=%0d exp=0", digit_sel); end
        if (slot_tick !== 1'b0) begin failures++; $display("FAIL ar_slot_async got=%b exp=0", slot_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (anode_n !== 4'hF) begin failures++; $display("FAIL ar_idle_anode got=%b exp=1111", anode_n); end
        en = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks += 3;
            if (digit_sel !== ((k == 10) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL ar_re_sel k=%0d got=%0d", k, digit_sel); end
            if (anode_n !== ((k == 10) ? 4'hF : exp_anode(0, k, 1'b0))) begin failures++; $display("FAIL ar_re_anode k=%0d got=%b", k, anode_n); end
            if (slot_tick !== (k == 9)) begin failures++; $display("FAIL ar_re_slot k=%0d got=%b", k, slot_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_frame_wrap();
        test_mask();
        test_period_change();
        test_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
